// File: rtl/mmio_uart_if.sv
// CPU-side memory access bundle shared by the control unit (master) and
// memory-mapped responders such as the UART (slave).
interface mmio_uart_if;
  logic [15:0] memAddr;
  logic        memRe;
  logic        memWe;
  logic [15:0] memWBus;
  logic [15:0] memRBus;
  logic        clkHold;

  modport master (
    output memAddr, memRe, memWe, memWBus,
    input  memRBus, clkHold
  );

  modport slave (
    input  memAddr, memRe, memWe, memWBus,
    output memRBus, clkHold
  );
endinterface

// File: rtl/mmio_uart.sv
// Memory-mapped UART: 4-word register window, TX FIFO with CPU stall on full,
// single-byte RX holding register with overrun and framing-error flags.
module mmio_uart #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  mmio_uart_if.slave  bus,
  input  logic        uartRx,
  output logic        uartTx
);

  localparam int PW   = $clog2(TX_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] BIT_END  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_END = CNTW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          hit;
  logic [1:0]    offset;
  logic          tx_full, tx_empty, tx_busy;
  logic          wr_commit, tx_push, tx_pop, stat_wr, rx_pop;
  logic [15:0]   rdata;
  logic          unused_wbus;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] tx_count_q, tx_count_d;

  tx_state_t     tx_state_q;
  logic [CNTW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_byte_q;
  logic          tx_line_q;
  logic          tx_bit_end;

  rx_state_t     rx_state_q;
  logic [CNTW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_byte_q;
  logic          rx_meta_q, rx_sync_q;
  logic          rx_valid_q, overrun_q, frame_err_q;

  assign hit      = bus.memAddr[15:2] == BASE_ADDR[15:2];
  assign offset   = bus.memAddr[1:0];
  assign tx_full  = tx_count_q == CW'(TX_DEPTH);
  assign tx_empty = tx_count_q == '0;
  assign tx_busy  = tx_state_q != TX_IDLE;

  // Stall depends only on registered fullness, so a pop on the same edge
  // cannot release the write until the following cycle.
  assign bus.clkHold = hit & bus.memWe & (offset == 2'd0) & tx_full;
  assign wr_commit   = hit & bus.memWe & ~bus.clkHold;
  assign tx_push     = wr_commit & (offset == 2'd0);
  assign stat_wr     = wr_commit & (offset == 2'd1);
  assign rx_pop      = hit & bus.memRe & ~bus.memWe & (offset == 2'd0);
  assign unused_wbus = ^bus.memWBus[15:8];

  always_comb begin
    rdata = 16'h0000;
    if (hit & bus.memRe) begin
      case (offset)
        2'd0:    rdata = {8'h00, rx_byte_q};
        2'd1:    rdata = {10'b0, frame_err_q, tx_busy, overrun_q, rx_valid_q, tx_full, tx_empty};
        default: rdata = 16'h0000;
      endcase
    end
  end
  assign bus.memRBus = rdata;

  // TX FIFO
  assign tx_bit_end = tx_cnt_q == BIT_END;
  assign tx_pop = ~tx_empty & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_bit_end));

  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr_q] <= bus.memWBus[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      tx_count_q <= tx_count_d;
    end
  end

  // TX FSM: the line level is registered and changes only on state/bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_byte_q  <= fifo_mem[rd_ptr_q];
            tx_line_q  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_byte_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CNTW'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_line_q  <= 1'b1;
            end else begin
              tx_bit_q  <= tx_bit_q + 3'd1;
              tx_line_q <= tx_byte_q[tx_bit_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNTW'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_state_q <= TX_START;
              tx_byte_q  <= fifo_mem[rd_ptr_q];
              tx_line_q  <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNTW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end
  assign uartTx = tx_line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uartRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX FSM plus holding register; later assignments (delivery, flag set) win
  // over the pop/clear defaults at the top of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_pop) rx_valid_q <= 1'b0;
      if (stat_wr & bus.memWBus[3]) overrun_q   <= 1'b0;
      if (stat_wr & bus.memWBus[5]) frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNTW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNTW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              if (!rx_valid_q || rx_pop) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNTW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboard bench for mmio_uart: reads and serial TX frames are queued as
// expectations and checked by independent monitors.
module tb_mmio_uart;
  localparam int CPB = 4;

  logic clk, rst, uartRx, uartTx;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   tx_abort = 0;

  typedef struct { logic [15:0] addr; logic [15:0] exp; } rd_t;
  typedef struct { logic [7:0] data; bit b2b; } tx_t;
  rd_t rd_q[$];
  tx_t tx_q[$];

  mmio_uart_if bus();

  mmio_uart #(.BASE_ADDR(16'hFF00), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uartRx(uartRx), .uartTx(uartTx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Read monitor: every cycle with memRe high is one read response.
  always @(negedge clk) begin
    rd_t e;
    if (bus.memRe === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: addr %h got %h required no read", bus.memAddr, bus.memRBus);
      end else begin
        e = rd_q.pop_front();
        $display("rd %h -> %h (expect %h)", e.addr, bus.memRBus, e.exp);
        check($sformatf("rd_%h", e.addr), {16'h0, bus.memRBus}, {16'h0, e.exp});
      end
    end
  end

  // TX monitor: checks every clock of each 10-bit frame and back-to-back spacing.
  initial begin
    int start_c, last_end, idx;
    tx_t e;
    logic [7:0] got;
    logic exp_bit;
    bit bad, aborted, have;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (uartTx === 1'b0 && !tx_abort) begin
        start_c = cyc;
        have = tx_q.size() != 0;
        if (have) e = tx_q.pop_front();
        else begin e.data = 8'h00; e.b2b = 0; end
        got = 8'h00; bad = 0; aborted = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (tx_abort) begin aborted = 1; break; end
          idx = (k >= CPB) ? (k - CPB) / CPB : 0;
          exp_bit = (k < CPB) ? 1'b0 : (k >= 9 * CPB) ? 1'b1 : e.data[idx];
          if (uartTx !== exp_bit) bad = 1;
          if (k >= CPB && k < 9 * CPB && ((k - CPB) % CPB) == CPB / 2) got[idx] = uartTx;
        end
        if (!aborted) begin
          $display("tx frame %h at cycle %0d (expect %h)", got, start_c, e.data);
          if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got frame %h required none", got);
          end else begin
            check("tx_byte", {24'h0, got}, {24'h0, e.data});
            check("tx_frame_timing", {31'h0, bad}, 32'h0);
            if (e.b2b) check("tx_no_gap", start_c, last_end + 1);
          end
          last_end = cyc;
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d, output int stall);
    @(posedge clk); #1;
    bus.memAddr = a; bus.memWBus = d; bus.memWe = 1'b1;
    #1;
    stall = 0;
    while (bus.clkHold === 1'b1 && stall < 200) begin
      @(posedge clk); #2;
      stall++;
    end
    @(posedge clk); #1;
    bus.memWe = 1'b0; bus.memAddr = 16'h0000;
    $display("wr %h <= %h (stall %0d)", a, d, stall);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp);
    rd_t e;
    e.addr = a; e.exp = exp;
    rd_q.push_back(e);
    @(posedge clk); #1;
    bus.memAddr = a; bus.memRe = 1'b1;
    @(posedge clk); #1;
    bus.memRe = 1'b0; bus.memAddr = 16'h0000;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit b2b);
    tx_t e;
    e.data = b; e.b2b = b2b;
    tx_q.push_back(e);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    $display("rx drive byte %h stop %0b", b, stop);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 uartRx = frame[i];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 uartRx = 1'b1;
  endtask

  initial begin
    int stall, t;
    rst = 1'b1; uartRx = 1'b1;
    bus.memAddr = 16'h0000; bus.memRe = 1'b0; bus.memWe = 1'b0; bus.memWBus = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_uartTx", {31'h0, uartTx}, 32'h1);
    check("reset_clkHold", {31'h0, bus.clkHold}, 32'h0);
    check("idle_memRBus", {16'h0, bus.memRBus}, 32'h0);
    rd(16'hFF01, 16'h0001);

    // Single byte, then five more queued behind it; the last must stall.
    wr(16'hFF00, 16'h1255, stall);
    push_tx(8'h55, 0);
    rd(16'hFF01, 16'h0011);
    for (int b = 1; b <= 5; b++) begin
      push_tx(8'(b), 1);
      wr(16'hFF00, 16'(b), stall);
      if (b < 5) check($sformatf("wr%0d_no_stall", b), stall, 0);
      else check("wr5_stalled", {31'h0, (stall > 0 && stall < 45)}, 32'h1);
    end
    t = 0;
    while (tx_q.size() != 0 && t < 400) begin @(posedge clk); t++; end
    check("tx_drain", tx_q.size(), 0);
    repeat (45) @(posedge clk);
    rd(16'hFF01, 16'h0001);

    // Receive path
    send_rx(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    rd(16'hFF01, 16'h0005);
    rd(16'hFF00, 16'h00A5);
    rd(16'hFF01, 16'h0001);

    send_rx(8'h3C, 1'b1);
    send_rx(8'hC3, 1'b1);
    repeat (3) @(posedge clk);
    rd(16'hFF01, 16'h000D);
    wr(16'hFF01, 16'h0008, stall);
    rd(16'hFF01, 16'h0005);
    rd(16'hFF00, 16'h003C);
    rd(16'hFF01, 16'h0001);

    send_rx(8'h77, 1'b0);
    repeat (8) @(posedge clk);
    rd(16'hFF01, 16'h0021);
    wr(16'hFF01, 16'h0020, stall);
    rd(16'hFF01, 16'h0001);
    @(posedge clk); #1 uartRx = 1'b0;
    @(posedge clk); #1 uartRx = 1'b1;
    repeat (20) @(posedge clk);
    rd(16'hFF01, 16'h0001);

    // Reset in the middle of a frame with a second byte still queued.
    wr(16'hFF00, 16'h0081, stall);
    push_tx(8'h81, 0);
    wr(16'hFF00, 16'h0082, stall);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; tx_abort = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_uartTx", {31'h0, uartTx}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    tx_abort = 0;
    rd(16'hFF01, 16'h0001);
    rd(16'hFF02, 16'h0000);
    rd(16'hFF03, 16'h0000);
    rd(16'h1234, 16'h0000);
    rd(16'hFF04, 16'h0000);
    repeat (60) @(posedge clk);

    check("rd_q_drained", rd_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
